// File: rtl/sap_prog_loader.sv
// SAP-1 program-mode loader: debounces the write button and turns each press
// into one clean RAM write cycle (SETUP, WRITE, HOLD) with optional auto-increment addressing.
module sap_prog_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned WR_PULSE        = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run_prog,
  input  logic       btn_wr,
  input  logic       addr_mode,
  input  logic [3:0] sw_addr,
  input  logic [7:0] sw_data,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       data_oe,
  output logic       ram_nce,
  output logic       ram_nwr,
  output logic       busy,
  output logic [3:0] cur_addr,
  output logic [4:0] wr_count,
  output logic       load_done
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned WpW = $clog2(WR_PULSE + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StWrite, StHold, StWaitRel} state_e;

  state_e           state;
  logic             sync1, sync2;
  logic             level;
  logic             press;
  logic [DbW-1:0]   db_cnt;
  logic [WpW-1:0]   wp_cnt;

  // Synchronizer and debouncer; press pulses for one cycle on an accepted rise.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      level  <= 1'b0;
      press  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= btn_wr;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DbW'(DEBOUNCE_CYCLES - 1)) begin
        level  <= sync2;
        press  <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= StIdle;
      wp_cnt    <= '0;
      ram_addr  <= 4'h0;
      ram_data  <= 8'h00;
      data_oe   <= 1'b0;
      ram_nce   <= 1'b1;
      ram_nwr   <= 1'b1;
      busy      <= 1'b0;
      cur_addr  <= 4'h0;
      wr_count  <= 5'd0;
      load_done <= 1'b0;
    end else if (run_prog) begin
      // Run mode aborts any write in flight without touching counters.
      state   <= StIdle;
      data_oe <= 1'b0;
      ram_nce <= 1'b1;
      ram_nwr <= 1'b1;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (press) begin
            state    <= StSetup;
            ram_addr <= addr_mode ? sw_addr : cur_addr;
            ram_data <= sw_data;
            ram_nce  <= 1'b0;
            data_oe  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StSetup: begin
          state   <= StWrite;
          ram_nwr <= 1'b0;
          wp_cnt  <= '0;
        end
        StWrite: begin
          if (wp_cnt == WpW'(WR_PULSE - 1)) begin
            state   <= StHold;
            ram_nwr <= 1'b1;
          end else begin
            wp_cnt <= wp_cnt + 1'b1;
          end
        end
        StHold: begin
          state   <= StWaitRel;
          ram_nce <= 1'b1;
          data_oe <= 1'b0;
          busy    <= 1'b0;
          if (wr_count != 5'd16) wr_count <= wr_count + 5'd1;
          if (ram_addr == 4'hF) load_done <= 1'b1;
          if (!addr_mode) cur_addr <= ram_addr + 4'd1;
        end
        StWaitRel: begin
          if (!level) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_prog_loader.sv
// Bench for sap_prog_loader: table-driven presses plus hand-written corner cases,
// with a write scoreboard checked by a monitor on every ram_nwr rising edge.
module tb_sap_prog_loader;

  localparam int unsigned Db = 4;
  localparam int unsigned Wp = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       run_prog = 1'b0;
  logic       btn_wr = 1'b0;
  logic       addr_mode = 1'b0;
  logic [3:0] sw_addr = 4'h0;
  logic [7:0] sw_data = 8'h00;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       data_oe, ram_nce, ram_nwr, busy, load_done;
  logic [3:0] cur_addr;
  logic [4:0] wr_count;

  sap_prog_loader #(.DEBOUNCE_CYCLES(Db), .WR_PULSE(Wp)) dut (
    .clk(clk), .clr(clr), .run_prog(run_prog), .btn_wr(btn_wr), .addr_mode(addr_mode),
    .sw_addr(sw_addr), .sw_data(sw_data), .ram_addr(ram_addr), .ram_data(ram_data),
    .data_oe(data_oe), .ram_nce(ram_nce), .ram_nwr(ram_nwr), .busy(busy),
    .cur_addr(cur_addr), .wr_count(wr_count), .load_done(load_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic       mode;
    logic [3:0] sa;
    logic [7:0] sd;
    logic [3:0] ea;
    logic [3:0] ecur;
    logic [4:0] ecnt;
    logic       eld;
  } vec_t;

  wr_t  sb[$];
  vec_t vt[5];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b1;
  logic chk_width = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the RAM latches on the nwr rising edge, so writes are scored there.
  logic       p_nwr = 1'b1, p_nce = 1'b1;
  logic [3:0] p_addr = 4'h0;
  logic [7:0] p_data = 8'h00;
  int         nwr_len = 0, nce_len = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (p_nwr && !ram_nwr) begin
        chk("addr_stable_at_nwr_fall", {28'd0, ram_addr}, {28'd0, p_addr});
        chk("data_stable_at_nwr_fall", {24'd0, ram_data}, {24'd0, p_data});
        chk("strobes_at_nwr_fall", {30'd0, ram_nce, data_oe}, 32'd1);
      end
      if (!p_nwr && ram_nwr) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {20'd0, ram_addr, ram_data}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("write_addr", {28'd0, p_addr}, {28'd0, e.a});
          chk("write_data", {24'd0, p_data}, {24'd0, e.d});
          if (chk_width) chk("nwr_low_cycles", nwr_len, Wp);
        end
      end
      if (!p_nce && ram_nce && chk_width) chk("nce_low_cycles", nce_len, Wp + 2);
    end
    nwr_len = ram_nwr ? 0 : nwr_len + 1;
    nce_len = ram_nce ? 0 : nce_len + 1;
    p_nwr  = ram_nwr;
    p_nce  = ram_nce;
    p_addr = ram_addr;
    p_data = ram_data;
  end

  task automatic press(input int hold);
    @(posedge clk); #1 btn_wr = 1'b1;
    repeat (hold) @(posedge clk);
    #1 btn_wr = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic wait_nwr_low();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!ram_nwr) seen = 1;
    end
    if (!seen) chk("nwr_low_timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    sb.push_back(w);
  endtask

  task automatic chk_state(input string n, input logic [3:0] ecur, input logic [4:0] ecnt,
                           input logic eld);
    chk({n, "_cur_addr"}, {28'd0, cur_addr}, {28'd0, ecur});
    chk({n, "_wr_count"}, {27'd0, wr_count}, {27'd0, ecnt});
    chk({n, "_load_done"}, {31'd0, load_done}, {31'd0, eld});
    chk({n, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, "_addr_data"}, {20'd0, ram_addr, ram_data}, 32'd0);
    chk({n, "_strobes"}, {28'd0, data_oe, ram_nce, ram_nwr, busy}, 32'b0110);
    chk({n, "_counters"}, {22'd0, load_done, wr_count, cur_addr}, 32'd0);
  endtask

  initial begin
    vt[0] = '{1'b0, 4'h0, 8'h1A, 4'h0, 4'h1, 5'd1, 1'b0};
    vt[1] = '{1'b1, 4'h7, 8'hE0, 4'h7, 4'h1, 5'd2, 1'b0};
    vt[2] = '{1'b0, 4'h9, 8'h33, 4'h1, 4'h2, 5'd3, 1'b0};
    vt[3] = '{1'b1, 4'hF, 8'h5A, 4'hF, 4'h2, 5'd4, 1'b1};
    vt[4] = '{1'b0, 4'h3, 8'h44, 4'h2, 4'h3, 5'd5, 1'b1};

    #12;
    chk_reset_vals("reset");
    @(posedge clk); #1 clr = 1'b0;

    foreach (vt[i]) begin
      addr_mode = vt[i].mode;
      sw_addr   = vt[i].sa;
      sw_data   = vt[i].sd;
      push(vt[i].ea, vt[i].sd);
      press(14);
      chk_state($sformatf("vec%0d", i), vt[i].ecur, vt[i].ecnt, vt[i].eld);
    end

    // Manual mode: data switches change mid-write, latched value must be kept.
    addr_mode = 1'b1; sw_addr = 4'h7; sw_data = 8'hE0;
    push(4'h7, 8'hE0);
    @(posedge clk); #1 btn_wr = 1'b1;
    wait_nwr_low();
    sw_data = 8'h55;
    repeat (10) @(posedge clk);
    #1 btn_wr = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk_state("manual_change", 4'h3, 5'd6, 1'b1);

    // Bouncy press.
    addr_mode = 1'b0; sw_data = 8'h66;
    push(4'h3, 8'h66);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 btn_wr = (i != 1);
    end
    press(10);
    chk_state("bounce", 4'h4, 5'd7, 1'b1);

    // Long hold writes once; a second press writes again.
    sw_data = 8'h77;
    push(4'h4, 8'h77);
    press(100);
    chk_state("hold100", 4'h5, 5'd8, 1'b1);
    sw_data = 8'h88;
    push(4'h5, 8'h88);
    press(14);
    chk_state("repress", 4'h6, 5'd9, 1'b1);

    // Press in run mode: no RAM activity.
    run_prog = 1'b1;
    press(14);
    run_prog = 1'b0;
    chk_state("run_press", 4'h6, 5'd9, 1'b1);

    // run_prog abort during WRITE.
    mon_en = 1'b0;
    @(posedge clk); #1 btn_wr = 1'b1;
    wait_nwr_low();
    run_prog = 1'b1;
    @(negedge clk);
    chk("abort_strobes", {28'd0, data_oe, ram_nce, ram_nwr, busy}, 32'b0110);
    #1 btn_wr = 1'b0;
    repeat (12) @(posedge clk);
    #1 run_prog = 1'b0;
    chk_state("abort", 4'h6, 5'd9, 1'b1);
    mon_en = 1'b1;

    // Async clear during WRITE.
    mon_en = 1'b0;
    @(posedge clk); #1 btn_wr = 1'b1;
    wait_nwr_low();
    #1 clr = 1'b1;
    #1 chk_reset_vals("clr_async");
    btn_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    mon_en = 1'b1;

    // Fill all 16 words, then one more that wraps to address 0.
    addr_mode = 1'b0;
    for (int i = 0; i < 17; i++) begin
      sw_data = 8'(i);
      push(4'(i), 8'(i));
      press(14);
      if (i == 14) chk("load_done_before_16th", {31'd0, load_done}, 32'd0);
    end
    chk_state("fill17", 4'h1, 5'd16, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
